// File: rtl/noekeon_iter_core.sv
// rtl/noekeon_iter_core.sv - iterative Noekeon direct-key block cipher core
//
// Purpose: encrypts or decrypts one 128-bit block with a 128-bit working key,
// running ROUNDS_PER_CYCLE rounds per clock, followed by one output-transform cycle.
// Word order: word a0 is bits [31:0], a1 is [63:32], a2 is [95:64], a3 is [127:96].
// The round constant is applied to bits [7:0].
// Ports:
//   inClk, inRstN         clock; asynchronous active-low reset
//   inValid/outReady      request handshake (inData, inKey, inDecipher)
//   outValid/inReady      result handshake (outData, registered)
module noekeon_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inValid,
  output logic         outReady,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  input  logic         inDecipher,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outData
);

  localparam bit LEGAL_R = (ROUNDS_PER_CYCLE == 1) || (ROUNDS_PER_CYCLE == 2) ||
                           (ROUNDS_PER_CYCLE == 4) || (ROUNDS_PER_CYCLE == 8) ||
                           (ROUNDS_PER_CYCLE == 16);
  if (!LEGAL_R) begin : g_bad_rounds
    $error("noekeon_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] st, key_q, run_st, fin_st;
  logic [7:0]   rc, run_rc;
  logic [4:0]   cnt, cnt_next;
  logic         mode;
  logic         accept, run_last;

  function automatic logic [31:0] mix8(input logic [31:0] t);
    return t ^ {t[23:0], t[31:24]} ^ {t[7:0], t[31:8]};
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] a);
    logic [31:0] a0, a1, a2, a3, t;
    {a3, a2, a1, a0} = a;
    t  = mix8(a0 ^ a2);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[31:0];
    a1 = a1 ^ k[63:32];
    a2 = a2 ^ k[95:64];
    a3 = a3 ^ k[127:96];
    t  = mix8(a1 ^ a3);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {s[125:96], s[127:126], s[90:64], s[95:91], s[62:32], s[63], s[31:0]};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {s[97:96], s[127:98], s[68:64], s[95:69], s[32], s[63:33], s[31:0]};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a3, a2, a1, a0} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a3, a2, a1, a0};
  endfunction

  // Encrypt adds the constant before Theta, decrypt after it.
  function automatic logic [127:0] nk_round(input logic [127:0] k, input logic [127:0] a,
                                            input logic [7:0] c, input logic dec);
    logic [127:0] s;
    s = dec ? a : (a ^ {120'b0, c});
    s = theta(k, s);
    if (dec) s[7:0] = s[7:0] ^ c;
    return pi2(gamma(pi1(s)));
  endfunction

  function automatic logic [7:0] rc_step(input logic [7:0] c, input logic dec);
    if (dec) return c[0] ? (((c ^ 8'h1B) >> 1) | 8'h80) : (c >> 1);
    return {c[6:0], 1'b0} ^ (c[7] ? 8'h1B : 8'h00);
  endfunction

  // Unrolled round chain; the constant advances once per round.
  always_comb begin
    run_st = st;
    run_rc = rc;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      run_st = nk_round(key_q, run_st, run_rc, mode);
      run_rc = rc_step(run_rc, mode);
    end
    fin_st = mode ? (theta(key_q, st) ^ {120'b0, rc}) : theta(key_q, st ^ {120'b0, rc});
  end

  assign cnt_next = cnt + CNT_STEP;
  assign run_last = (cnt_next == 5'd16);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    outReady   = 1'b0;
    outValid   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        outReady = 1'b1;
        if (inValid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN:   if (run_last) state_next = FINAL;
      FINAL: state_next = DONE;
      DONE: begin
        outValid = 1'b1;
        if (inReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      st      <= '0;
      key_q   <= '0;
      rc      <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      outData <= '0;
    end else begin
      if (accept) begin
        st    <= inData;
        mode  <= inDecipher;
        // Decryption uses the Theta-transformed key throughout.
        key_q <= inDecipher ? theta(128'b0, inKey) : inKey;
        rc    <= inDecipher ? 8'hD4 : 8'h80;
        cnt   <= '0;
      end
      if (state == RUN) begin
        st  <= run_st;
        rc  <= run_rc;
        cnt <= cnt_next;
      end
      if (state == FINAL) outData <= fin_st;
    end
  end

endmodule
